// File: rtl/chan_requester.sv
// Per-port requester for the crossbar channel arbiter: takes a packet descriptor,
// requests the channel, waits for the grant pulse, then streams the packet out of the data FIFO.
module chan_requester #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int WAIT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_desc_vld,
    input  logic [LEN_W-1:0]  i_desc_len,
    output logic              o_desc_rdy,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_chann_req,
    input  logic              i_chan_resp,
    input  logic              i_chan_nresp,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_vld,
    output logic              o_end,
    output logic [WAIT_W-1:0] o_wait_cnt,
    output logic              o_proto_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              perr_q, perr_d;
    logic              vld_q, end_q;
    logic              rd_en;
    logic              last_rd;

    // Not-granted only tells us we lost this round; the request is simply held.
    logic unused_nresp;
    assign unused_nresp = i_chan_nresp;

    assign rd_en   = (state_q == ST_XFER);
    assign last_rd = rd_en && (cnt_q == (len_q - LEN_ONE));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        perr_d  = perr_q;

        case (state_q)
            ST_IDLE: begin
                // A zero-length descriptor is accepted and dropped without requesting.
                if (i_desc_vld && (i_desc_len != '0)) begin
                    len_d   = i_desc_len;
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + WAIT_ONE;
                end
                if (i_chan_resp) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                cnt_d = cnt_q + LEN_ONE;
                if (last_rd) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_chan_resp && (state_q != ST_REQ)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            perr_q  <= 1'b0;
            vld_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            perr_q  <= perr_d;
            vld_q   <= rd_en;
            end_q   <= last_rd;
        end
    end

    assign o_desc_rdy  = (state_q == ST_IDLE);
    assign o_chann_req = (state_q == ST_REQ);
    assign o_rd_en     = rd_en;
    assign o_data      = i_rd_data;
    assign o_data_vld  = vld_q;
    assign o_end       = end_q;
    assign o_wait_cnt  = wait_q;
    assign o_proto_err = perr_q;

endmodule

// File: tb/tb_chan_requester.sv
// Directed testbench for chan_requester: reference packet timing, contention, length
// boundaries, wait saturation, spurious grants and asynchronous reset mid-transfer.
module tb_chan_requester;

    localparam int MAXC = 700;

    logic        clk;
    logic        rst_n;
    logic        desc_vld;
    logic [7:0]  desc_len;
    logic        desc_rdy;
    logic        rd_en;
    logic [31:0] rd_data = 32'h5A5A_0000;
    logic        chann_req;
    logic        chan_resp;
    logic        chan_nresp;
    logic [31:0] data;
    logic        data_vld;
    logic        end_s;
    logic [7:0]  wait_cnt;
    logic        proto_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int rd_ptr       = 0;

    // Per-cycle trace of one packet: ctl = {rdy, req, rd_en, data_vld, end}
    logic [4:0]  ctl_tr  [0:MAXC-1];
    logic [31:0] data_tr [0:MAXC-1];
    logic [7:0]  wait_tr [0:MAXC-1];
    logic        perr_seen;

    chan_requester dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_desc_vld   (desc_vld),
        .i_desc_len   (desc_len),
        .o_desc_rdy   (desc_rdy),
        .o_rd_en      (rd_en),
        .i_rd_data    (rd_data),
        .o_chann_req  (chann_req),
        .i_chan_resp  (chan_resp),
        .i_chan_nresp (chan_nresp),
        .o_data       (data),
        .o_data_vld   (data_vld),
        .o_end        (end_s),
        .o_wait_cnt   (wait_cnt),
        .o_proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data FIFO model with a fixed one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= 32'hC0DE_0000 + 32'(rd_ptr);
            rd_ptr  <= rd_ptr + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected control flags in cycle c for grant cycle g_cyc and length len.
    function automatic logic [4:0] exp_ctl(input int c, input int g_cyc, input int len);
        logic rdy, req, rd, vld, en;
        rdy = (c == 0) || (c >= g_cyc + len + 2);
        req = (c >= 1) && (c <= g_cyc);
        rd  = (c >= g_cyc + 1) && (c <= g_cyc + len);
        vld = (c >= g_cyc + 2) && (c <= g_cyc + len + 1);
        en  = (c == g_cyc + len + 1);
        return {rdy, req, rd, vld, en};
    endfunction

    function automatic int exp_wait(input int c, input int g_cyc);
        int v;
        v = (c <= g_cyc) ? c - 1 : g_cyc;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic sample(input int c);
        ctl_tr[c]  = {desc_rdy, chann_req, rd_en, data_vld, end_s};
        data_tr[c] = data;
        wait_tr[c] = wait_cnt;
        perr_seen  = perr_seen | proto_err;
    endtask

    // Issue one descriptor and grant after g idle cycles; record ncyc cycles of outputs.
    task automatic drive_packet(input int len, input int g, input int ncyc, output int sptr);
        perr_seen = 1'b0;
        sptr      = rd_ptr;
        desc_vld  = 1'b1;
        desc_len  = 8'(len);
        sample(0);
        tick;
        desc_vld = 1'b0;
        desc_len = '0;
        for (int c = 1; c <= ncyc; c++) begin
            chan_resp = (c == 2 + g);
            sample(c);
            tick;
        end
        chan_resp = 1'b0;
    endtask

    task automatic test_reset;
        tests_run++;
        if ({desc_rdy, chann_req, rd_en, data_vld, end_s} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_ctl: got %b expected 10000", {desc_rdy, chann_req, rd_en, data_vld, end_s});
        end
        tests_run++;
        if ({wait_cnt, proto_err} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: wait %0d perr %b expected 0 0", wait_cnt, proto_err);
        end
        tests_run++;
        if (data !== 32'h5A5A_0000) begin
            tests_failed++;
            $display("FAIL reset_passthru: got %h expected 5a5a0000", data);
        end
    endtask

    task automatic test_single;
        int sp;
        drive_packet(4, 0, 9, sp);
        for (int c = 0; c <= 9; c++) begin
            tests_run++;
            if (ctl_tr[c] !== exp_ctl(c, 2, 4)) begin
                tests_failed++;
                $display("FAIL single_ctl cycle %0d: got %b expected %b", c, ctl_tr[c], exp_ctl(c, 2, 4));
            end
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (data_tr[4 + k] !== 32'hC0DE_0000 + 32'(sp + k)) begin
                tests_failed++;
                $display("FAIL single_data word %0d: got %h expected %h", k, data_tr[4 + k], 32'hC0DE_0000 + 32'(sp + k));
            end
        end
        tests_run++;
        if (wait_tr[1] !== 8'd0 || wait_tr[2] !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_wait: got %0d,%0d expected 0,1", wait_tr[1], wait_tr[2]);
        end
    endtask

    task automatic test_contention;
        int sp;
        drive_packet(3, 10, 18, sp);
        for (int c = 0; c <= 18; c++) begin
            tests_run++;
            if (ctl_tr[c] !== exp_ctl(c, 12, 3)) begin
                tests_failed++;
                $display("FAIL contend_ctl cycle %0d: got %b expected %b", c, ctl_tr[c], exp_ctl(c, 12, 3));
            end
        end
        tests_run++;
        if (wait_tr[12] !== 8'd11) begin
            tests_failed++;
            $display("FAIL contend_wait_at_grant: got %0d expected 11", wait_tr[12]);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (data_tr[14 + k] !== 32'hC0DE_0000 + 32'(sp + k)) begin
                tests_failed++;
                $display("FAIL contend_data word %0d: got %h expected %h", k, data_tr[14 + k], 32'hC0DE_0000 + 32'(sp + k));
            end
        end
        tests_run++;
        if (perr_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL contend_proto_err: got %b expected 0", perr_seen);
        end
    endtask

    task automatic test_len_one;
        int sp;
        drive_packet(1, 0, 6, sp);
        for (int c = 0; c <= 6; c++) begin
            tests_run++;
            if (ctl_tr[c] !== exp_ctl(c, 2, 1)) begin
                tests_failed++;
                $display("FAIL len1_ctl cycle %0d: got %b expected %b", c, ctl_tr[c], exp_ctl(c, 2, 1));
            end
        end
        tests_run++;
        if (data_tr[4] !== 32'hC0DE_0000 + 32'(sp)) begin
            tests_failed++;
            $display("FAIL len1_data: got %h expected %h", data_tr[4], 32'hC0DE_0000 + 32'(sp));
        end
    endtask

    task automatic test_len_max;
        int sp, nvld, nend, nbad;
        drive_packet(255, 0, 260, sp);
        nvld = 0;
        nend = 0;
        nbad = 0;
        for (int c = 0; c <= 260; c++) begin
            nvld += int'(ctl_tr[c][1]);
            nend += int'(ctl_tr[c][0]);
            if (ctl_tr[c] !== exp_ctl(c, 2, 255)) nbad++;
            if (ctl_tr[c][1] && data_tr[c] !== 32'hC0DE_0000 + 32'(sp + c - 4)) nbad++;
        end
        tests_run++;
        if (nvld != 255 || nend != 1) begin
            tests_failed++;
            $display("FAIL len255_count: vld %0d end %0d expected 255 1", nvld, nend);
        end
        tests_run++;
        if (nbad != 0) begin
            tests_failed++;
            $display("FAIL len255_trace: %0d bad cycles expected 0", nbad);
        end
        tests_run++;
        if (ctl_tr[258] !== 5'b00011 || ctl_tr[259] !== 5'b10000) begin
            tests_failed++;
            $display("FAIL len255_end: got %b,%b expected 00011,10000", ctl_tr[258], ctl_tr[259]);
        end
    endtask

    task automatic test_zero_len;
        logic [4:0] seen;
        tests_run++;
        if (desc_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_rdy: got %b expected 1", desc_rdy);
        end
        desc_vld = 1'b1;
        desc_len = 8'd0;
        tick;
        desc_vld = 1'b0;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            seen = seen | {~desc_rdy, chann_req, rd_en, data_vld, end_s};
            tick;
        end
        tests_run++;
        if (seen !== 5'b00000) begin
            tests_failed++;
            $display("FAIL zero_len_activity: got %b expected 00000", seen);
        end
    endtask

    task automatic test_wait_sat;
        int sp;
        drive_packet(2, 298, 305, sp);
        tests_run++;
        if (wait_tr[255] !== 8'd254 || wait_tr[256] !== 8'd255 || wait_tr[257] !== 8'd255) begin
            tests_failed++;
            $display("FAIL wait_sat_edge: got %0d,%0d,%0d expected 254,255,255", wait_tr[255], wait_tr[256], wait_tr[257]);
        end
        tests_run++;
        if (wait_tr[300] !== 8'(exp_wait(300, 300)) || chann_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_sat_grant: got %0d req %b expected 255 0", wait_tr[300], chann_req);
        end
        tests_run++;
        if (ctl_tr[299] !== exp_ctl(299, 300, 2) || ctl_tr[303] !== exp_ctl(303, 300, 2)) begin
            tests_failed++;
            $display("FAIL wait_sat_ctl: got %b,%b expected %b,%b", ctl_tr[299], ctl_tr[303], exp_ctl(299, 300, 2), exp_ctl(303, 300, 2));
        end
        tests_run++;
        if (perr_seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_sat_proto_err: got %b expected 0", perr_seen);
        end
    endtask

    task automatic test_proto_err;
        chan_resp = 1'b1;
        tick;
        chan_resp = 1'b0;
        tests_run++;
        if ({proto_err, desc_rdy, chann_req} !== 3'b110) begin
            tests_failed++;
            $display("FAIL proto_set: got %b expected 110", {proto_err, desc_rdy, chann_req});
        end
        for (int c = 0; c < 3; c++) tick;
        tests_run++;
        if ({proto_err, desc_rdy, chann_req, rd_en} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL proto_sticky: got %b expected 1100", {proto_err, desc_rdy, chann_req, rd_en});
        end
    endtask

    task automatic test_reset_mid;
        int sp;
        desc_vld = 1'b1;
        desc_len = 8'd5;
        tick;
        desc_vld = 1'b0;
        tick;
        chan_resp = 1'b1;
        tick;
        chan_resp = 1'b0;
        tick;
        tests_run++;
        if ({rd_en, data_vld} !== 2'b11) begin
            tests_failed++;
            $display("FAIL mid_pre_xfer: got %b expected 11", {rd_en, data_vld});
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({desc_rdy, chann_req, rd_en, data_vld, end_s} !== 5'b10000 || wait_cnt !== 8'd0 || proto_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: ctl %b wait %0d perr %b expected 10000 0 0",
                     {desc_rdy, chann_req, rd_en, data_vld, end_s}, wait_cnt, proto_err);
        end
        tests_run++;
        if (data !== rd_data) begin
            tests_failed++;
            $display("FAIL mid_reset_passthru: got %h expected %h", data, rd_data);
        end
        #3;
        rst_n = 1'b1;
        tick;
        drive_packet(2, 0, 7, sp);
        for (int c = 0; c <= 7; c++) begin
            tests_run++;
            if (ctl_tr[c] !== exp_ctl(c, 2, 2)) begin
                tests_failed++;
                $display("FAIL mid_after_ctl cycle %0d: got %b expected %b", c, ctl_tr[c], exp_ctl(c, 2, 2));
            end
        end
        tests_run++;
        if (data_tr[4] !== 32'hC0DE_0000 + 32'(sp) || data_tr[5] !== 32'hC0DE_0000 + 32'(sp + 1)) begin
            tests_failed++;
            $display("FAIL mid_after_data: got %h,%h expected %h,%h", data_tr[4], data_tr[5],
                     32'hC0DE_0000 + 32'(sp), 32'hC0DE_0000 + 32'(sp + 1));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        desc_vld   = 1'b0;
        desc_len   = '0;
        chan_resp  = 1'b0;
        chan_nresp = 1'b0;
        #2;
        test_reset;
        #10;
        rst_n = 1'b1;
        tick;
        test_single;
        test_contention;
        test_len_one;
        test_len_max;
        test_zero_len;
        test_wait_sat;
        test_proto_err;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/chan_requester.md
# chan_requester

Per-port requester side of the crossbar channel arbitration handshake. It accepts a packet descriptor from the port's input buffer, raises this port's request bit toward the 16-way channel arbiter, and waits for the one-cycle grant pulse. It then streams the packet words out of the port data FIFO and pulses an end strobe on the last word so the arbiter releases the channel. One instance sits on each input port; the 16 `o_chann_req` bits concatenate into the arbiter request vector, and the 16 `o_end` strobes are ORed into the arbiter end input.

## Interface

- `DATA_W`, default 32: width of one packet word.
- `LEN_W`, default 8: width of the descriptor length field, in words.
- `WAIT_W`, default 8: width of the saturating grant-wait counter.

- `i_clk`  in  1  clock; the single clock of the block.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_desc_vld`  in  1  packet descriptor valid.
- `i_desc_len`  in  LEN_W  packet length in words; 0 is illegal.
- `o_desc_rdy`  out  1  descriptor accept; high only in IDLE.
- `o_rd_en`  out  1  data FIFO read strobe; the FIFO has a fixed 1-cycle read latency.
- `i_rd_data`  in  DATA_W  data FIFO read data, valid the cycle after `o_rd_en`.
- `o_chann_req`  out  1  this port's request bit to the arbiter.
- `i_chan_resp`  in  1  this port's grant bit from the arbiter; a 1-cycle pulse.
- `i_chan_nresp`  in  1  this port's not-granted bit; informational, not used for control.
- `o_data`  out  DATA_W  channel data; combinational passthrough of `i_rd_data`.
- `o_data_vld`  out  1  channel data valid.
- `o_end`  out  1  last-word strobe; high together with the last `o_data_vld`.
- `o_wait_cnt`  out  WAIT_W  cycles spent in REQ for the current or last request; saturating.
- `o_proto_err`  out  1  sticky flag: a grant arrived outside REQ.

## Operation

- **FSM states:** IDLE, REQ, XFER, DRAIN.
- **IDLE:**
  - `o_desc_rdy` = 1.
  - On `i_desc_vld` with `i_desc_len` != 0: latch the length into `len_q`, clear the word counter and `o_wait_cnt`, go to REQ.
  - On `i_desc_vld` with `i_desc_len` == 0: consume the descriptor, stay in IDLE, issue no request.
- **REQ:**
  - `o_chann_req` = 1 every cycle.
  - `o_wait_cnt` increments by 1 each cycle and saturates at 2^WAIT_W−1.
  - On `i_chan_resp` = 1: go to XFER.
  - `i_chan_nresp` is ignored; the request is held indefinitely (fixed-priority arbiter, starvation visible only via `o_wait_cnt`).
- **XFER:**
  - `o_rd_en` = 1 every cycle; the word counter increments per read.
  - When the counter reaches `len_q`−1 (the last read issues): go to DRAIN.
- **DRAIN:**
  - One cycle: the last word is presented and `o_end` = 1.
  - Then go to IDLE.
- **Output datapath:**
  - `o_data_vld` is `o_rd_en` registered.
  - `o_end` is the last-read flag registered.
  - `o_data` = `i_rd_data`.
- **Protocol error:** `i_chan_resp` = 1 in IDLE, XFER or DRAIN sets `o_proto_err` (sticky until reset) and does not change state.
- **Counter width:** word counter is LEN_W bits; maximum packet is 2^LEN_W−1 words with no wrap.

## Timing

- **Reset values:**
  - FSM = IDLE.
  - `o_desc_rdy` = 1.
  - `o_chann_req` = 0, `o_rd_en` = 0, `o_data_vld` = 0, `o_end` = 0.
  - `o_wait_cnt` = 0, `o_proto_err` = 0.
  - `o_data` follows `i_rd_data`.
- **Reference sequence** (descriptor of length L accepted at the edge ending cycle 0, arbiter idle and ready):
  - cycle 1: `o_chann_req` = 1, `o_wait_cnt` = 0.
  - cycle 2: arbiter drives `i_chan_resp` = 1; `o_wait_cnt` = 1.
  - cycle 3: `o_chann_req` = 0, `o_rd_en` = 1; `o_rd_en` stays high through cycle 2+L.
  - cycles 4..3+L: `o_data_vld` = 1.
  - cycle 3+L: `o_end` = 1.
  - cycle 4+L: IDLE, `o_desc_rdy` = 1. The arbiter's ready returns in the same cycle.
- **Latency:**
  - Request to first data: 3 cycles when uncontended.
  - Grant to end pulse: L+1 cycles.
  - Back-to-back packets: new `o_chann_req` no earlier than cycle 5+L.
- `o_chann_req` is registered and drops on the edge after the grant is seen. The arbiter ignores requests while its ready is low, so there is no double grant.
- `o_end` is exactly 1 cycle wide, once per packet.
- **L = 1:** `o_rd_en` high for 1 cycle (cycle 3); `o_data_vld` and `o_end` both high in cycle 4.
- **Reset mid-operation:** all outputs return to reset values immediately (asynchronous). Any partial packet is lost, and the whole channel subsystem is reset together.

## Test plan

- **Single packet:** L=4, arbiter idle → `o_chann_req` high cycles 1–2; `o_rd_en` high cycles 3–6; data words D0..D3 on `o_data_vld` cycles 4–7; `o_end` at cycle 7 only; `o_desc_rdy` high at cycle 8.
- **Contention:** a higher-priority port holds the channel for 10 cycles → `o_chann_req` is held continuously; `o_wait_cnt` = 11 at the grant cycle; transfer then proceeds normally; `o_proto_err` stays 0.
- **Length boundaries:**
  - L=1 → one read, `o_end` coincides with the single valid word.
  - L=255 with LEN_W=8 → exactly 255 valid words, no counter wrap.
- **Zero length:** `i_desc_len` = 0 → descriptor consumed in one cycle; `o_chann_req`, `o_rd_en` and `o_end` never assert.
- **Wait saturation and spurious grant:**
  - Hold off the grant for 300 cycles with WAIT_W=8 → `o_wait_cnt` saturates at 255.
  - Pulse `i_chan_resp` in IDLE → `o_proto_err` = 1 and stays high; FSM stays in IDLE.
- **Reset mid-transfer:** assert `i_rst_n` low during XFER → all outputs return to reset values immediately. After release, a new L=2 packet completes with the reference timing.
